// File: rtl/nabp_processing_swappable_multi.sv
// Line-walking processing unit: issues mapper-driven RAM addresses per projection line,
// shifts returned samples into a P-tap window for the PEs, and handshakes swap/next-line.
module nabp_processing_swappable_multi #(
  parameter int DATA_W           = 16,
  parameter int S_W              = 10,
  parameter int FRAC_W           = 8,
  parameter int ACCU_W           = 20,
  parameter int NO_OF_PARTITIONS = 4,
  parameter int PARTITION_SIZE   = 8,
  parameter int NO_OF_LINES      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 sw_start,
  input  logic                                 sw_dir,
  input  logic [ACCU_W-1:0]                    sw_mp_accu_init,
  input  logic [ACCU_W-1:0]                    sw_mp_accu_base,
  input  logic [ACCU_W-1:0]                    sw_sh_accu_base,
  input  logic                                 sw_swap_ack,
  input  logic                                 sw_next_itr_ack,
  input  logic [DATA_W-1:0]                    fr_val,
  output logic [S_W-1:0]                       fr_s_val,
  output logic                                 sw_swap,
  output logic                                 sw_next_itr,
  output logic                                 sw_pe_en,
  output logic [DATA_W*NO_OF_PARTITIONS-1:0]   pe_taps,
  output logic [$clog2(NO_OF_LINES)-1:0]       line_itr,
  output logic                                 busy,
  output logic                                 done
);

  localparam int P        = NO_OF_PARTITIONS;
  localparam int PS       = PARTITION_SIZE;
  localparam int L        = NO_OF_LINES;
  localparam int LINE_LEN = P + PS - 1;
  localparam int TAP_W    = DATA_W * P;
  localparam int LI_W     = $clog2(L);
  localparam int IC_W     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int WC_W     = $clog2(P + 1);

  localparam logic [WC_W-1:0]          P_C   = WC_W'(P);
  localparam logic [IC_W-1:0]          IC_LAST = IC_W'(LINE_LEN - 1);
  localparam logic [LI_W-1:0]          LI_TOP  = LI_W'(L - 1);
  localparam logic signed [ACCU_W-1:0] S_MAX = ACCU_W'((2 ** S_W) - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SWAP, NEXT} state_t;

  state_t                     state_q, state_d;
  logic                       dir_q, dir_d;
  logic signed [ACCU_W-1:0]   init_q, init_d;
  logic signed [ACCU_W-1:0]   base_q, base_d;
  logic signed [ACCU_W-1:0]   shb_q, shb_d;
  logic signed [ACCU_W-1:0]   sh_q, sh_d;
  logic signed [ACCU_W-1:0]   mp_q, mp_d;
  logic [LI_W-1:0]            line_q, line_d;
  logic [IC_W-1:0]            icnt_q, icnt_d;
  logic [S_W-1:0]             s_val_q, s_val_d;
  logic                       vld_q, vld_d;
  logic                       vld1_q, vld1_d;
  logic [WC_W-1:0]            wcnt_q, wcnt_d, wcnt_inc;
  logic [TAP_W-1:0]           taps_q, taps_d;
  logic                       pe_en_q, pe_en_d;
  logic                       swap_q, swap_d;
  logic                       next_q, next_d;
  logic                       done_q, done_d;
  logic                       last_line;

  function automatic logic [S_W-1:0] sat_addr(input logic signed [ACCU_W-1:0] a);
    logic signed [ACCU_W-1:0] whole;
    whole = a >>> FRAC_W;
    if (whole < 0)          return '0;
    else if (whole > S_MAX) return '1;
    else                    return whole[S_W-1:0];
  endfunction

  assign last_line = dir_q ? (line_q == '0) : (line_q == LI_TOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    init_d   = init_q;
    base_d   = base_q;
    shb_d    = shb_q;
    sh_d     = sh_q;
    mp_d     = mp_q;
    line_d   = line_q;
    icnt_d   = icnt_q;
    s_val_d  = s_val_q;
    vld_d    = 1'b0;
    vld1_d   = vld_q;
    done_d   = 1'b0;
    taps_d   = taps_q;
    wcnt_d   = wcnt_q;
    pe_en_d  = 1'b0;
    wcnt_inc = (wcnt_q == P_C) ? wcnt_q : wcnt_q + WC_W'(1);

    // Window advances only on returned words; pe_en once it holds P of this line.
    if (vld1_q) begin
      taps_d  = {fr_val, taps_q[TAP_W-1:DATA_W]};
      wcnt_d  = wcnt_inc;
      pe_en_d = (wcnt_inc == P_C);
    end

    case (state_q)
      IDLE: begin
        if (sw_start) begin
          dir_d   = sw_dir;
          init_d  = sw_mp_accu_init;
          base_d  = sw_mp_accu_base;
          shb_d   = sw_sh_accu_base;
          sh_d    = '0;
          mp_d    = sw_mp_accu_init;
          line_d  = sw_dir ? LI_TOP : '0;
          icnt_d  = '0;
          wcnt_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s_val_d = sat_addr(mp_q);
        mp_d    = mp_q + base_q;
        vld_d   = 1'b1;
        icnt_d  = icnt_q + IC_W'(1);
        if (icnt_q == IC_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        // Hold until both the address and the data stage have emptied.
        if (!vld_q && !vld1_q) state_d = SWAP;
      end
      SWAP: begin
        if (sw_swap_ack) begin
          if (last_line) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (sw_next_itr_ack) begin
          line_d  = dir_q ? line_q - LI_W'(1) : line_q + LI_W'(1);
          sh_d    = sh_q + shb_q;
          mp_d    = init_q + sh_q + shb_q;
          icnt_d  = '0;
          wcnt_d  = '0;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    swap_d = (state_d == SWAP);
    next_d = (state_d == NEXT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q   <= 1'b0;
      init_q  <= '0;
      base_q  <= '0;
      shb_q   <= '0;
      sh_q    <= '0;
      mp_q    <= '0;
      line_q  <= '0;
      icnt_q  <= '0;
      s_val_q <= '0;
      vld_q   <= 1'b0;
      vld1_q  <= 1'b0;
      wcnt_q  <= '0;
      taps_q  <= '0;
      pe_en_q <= 1'b0;
      swap_q  <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      init_q  <= init_d;
      base_q  <= base_d;
      shb_q   <= shb_d;
      sh_q    <= sh_d;
      mp_q    <= mp_d;
      line_q  <= line_d;
      icnt_q  <= icnt_d;
      s_val_q <= s_val_d;
      vld_q   <= vld_d;
      vld1_q  <= vld1_d;
      wcnt_q  <= wcnt_d;
      taps_q  <= taps_d;
      pe_en_q <= pe_en_d;
      swap_q  <= swap_d;
      next_q  <= next_d;
      done_q  <= done_d;
    end
  end

  assign fr_s_val    = s_val_q;
  assign sw_swap     = swap_q;
  assign sw_next_itr = next_q;
  assign sw_pe_en    = pe_en_q;
  assign pe_taps     = taps_q;
  assign line_itr    = line_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_nabp_processing_swappable_multi.sv
// Scoreboard bench: a line-level reference model queues expected windows/swaps/done,
// a negedge monitor pops and compares them as the DUT presents each event.
module tb_nabp_processing_swappable_multi;

  localparam int DW = 16, SW = 10, FW = 8, AW = 20, P = 4, PS = 8, L = 8;
  localparam int TW = DW * P;
  localparam int EV_WIN = 0, EV_SWAP = 1, EV_DONE = 2;

  typedef struct {
    int            kind;
    int            line;
    logic [TW-1:0] taps;
    int            rel;
  } exp_t;

  logic                 clk, reset, sw_start, sw_dir, sw_swap_ack, sw_next_itr_ack;
  logic [AW-1:0]        sw_mp_accu_init, sw_mp_accu_base, sw_sh_accu_base;
  logic [DW-1:0]        fr_val;
  logic [SW-1:0]        fr_s_val;
  logic                 sw_swap, sw_next_itr, sw_pe_en, busy, done;
  logic [TW-1:0]        pe_taps;
  logic [$clog2(L)-1:0] line_itr;

  logic [DW-1:0] mem [1024];
  exp_t exp_q[$];
  int   swap_len_q[$], next_len_q[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc = 0, base_cyc = 0;
  int   ack_mode = 2;
  bit   spurious = 0, real_start = 0;

  nabp_processing_swappable_multi #(
    .DATA_W(DW), .S_W(SW), .FRAC_W(FW), .ACCU_W(AW),
    .NO_OF_PARTITIONS(P), .PARTITION_SIZE(PS), .NO_OF_LINES(L)
  ) dut (
    .clk(clk), .reset(reset), .sw_start(sw_start), .sw_dir(sw_dir),
    .sw_mp_accu_init(sw_mp_accu_init), .sw_mp_accu_base(sw_mp_accu_base),
    .sw_sh_accu_base(sw_sh_accu_base), .sw_swap_ack(sw_swap_ack),
    .sw_next_itr_ack(sw_next_itr_ack), .fr_val(fr_val), .fr_s_val(fr_s_val),
    .sw_swap(sw_swap), .sw_next_itr(sw_next_itr), .sw_pe_en(sw_pe_en),
    .pe_taps(pe_taps), .line_itr(line_itr), .busy(busy), .done(done)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  always @(posedge clk) fr_val <= mem[fr_s_val];

  function automatic void chk(input bit ok, input string name, input string det);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, det);
  endfunction

  // Two's-complement wrap of an arbitrary sum into the AW-bit signed range.
  function automatic longint wrap(input longint v);
    longint m;
    m = v % (longint'(1) << AW);
    if (m < 0) m += (longint'(1) << AW);
    if (m >= (longint'(1) << (AW - 1))) m -= (longint'(1) << AW);
    return m;
  endfunction

  function automatic longint floor_frac(input longint a);
    longint d;
    d = longint'(1) << FW;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int pick_delay();
    if (ack_mode == 0) return 0;
    if (ack_mode == 1) return 5;
    return int'($urandom_range(0, 4));
  endfunction

  task automatic expect_run(input bit dir, input int init, input int base, input int shb);
    exp_t e;
    int   samp [P+PS-1];
    for (int n = 0; n < L; n++) begin
      for (int k = 0; k < P + PS - 1; k++) begin
        longint idx;
        idx = floor_frac(wrap(longint'(init) + longint'(n) * shb + longint'(k) * base));
        if (idx < 0) idx = 0;
        if (idx > 1023) idx = 1023;
        samp[k] = int'(mem[int'(idx)]);
      end
      for (int j = 0; j < PS; j++) begin
        e.kind = EV_WIN; e.line = dir ? L - 1 - n : n; e.rel = P + 2 + j; e.taps = '0;
        for (int p = 0; p < P; p++) e.taps[p*DW +: DW] = DW'(samp[j+p]);
        exp_q.push_back(e);
      end
      e.kind = EV_SWAP; e.taps = '0; e.rel = P + PS + 2;
      exp_q.push_back(e);
    end
    e.kind = EV_DONE; e.line = 0; e.taps = '0; e.rel = -1;
    exp_q.push_back(e);
  endtask

  task automatic ev(input int kind, input string name);
    exp_t e;
    int   rel;
    bit   ok;
    rel = cyc - base_cyc;
    if (exp_q.size() == 0) begin
      chk(0, name, $sformatf("unexpected event line=%0d taps=%h at cycle %0d, want none", line_itr, pe_taps, cyc));
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == kind) && (e.rel < 0 || e.rel == rel);
    if (kind == EV_DONE) ok = ok && (busy == 1'b0);
    else                 ok = ok && (e.line == int'(line_itr));
    if (kind == EV_WIN)  ok = ok && (e.taps == pe_taps);
    chk(ok, name, $sformatf("got kind=%0d line=%0d taps=%h rel=%0d busy=%0b, want kind=%0d line=%0d taps=%h rel=%0d",
        kind, line_itr, pe_taps, rel, busy, e.kind, e.line, e.taps, e.rel));
  endtask

  initial begin : monitor
    int sw_len, nx_len;
    bit sw_prev;
    sw_len = 0; nx_len = 0; sw_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sw_len = 0; nx_len = 0; sw_prev = 0;
      end else begin
        if (sw_pe_en)             ev(EV_WIN, "window");
        if (sw_swap && !sw_prev)  ev(EV_SWAP, "swap_req");
        if (done)                 ev(EV_DONE, "done");
        if (sw_swap) sw_len++;
        else if (sw_len > 0) begin
          if (swap_len_q.size() == 0) chk(0, "swap_len", $sformatf("request of %0d cycles with no ack issued", sw_len));
          else begin
            int w; w = swap_len_q.pop_front();
            chk(sw_len == w, "swap_len", $sformatf("got %0d cycles, want %0d", sw_len, w));
          end
          sw_len = 0;
        end
        if (sw_next_itr) nx_len++;
        else if (nx_len > 0) begin
          if (next_len_q.size() == 0) chk(0, "next_len", $sformatf("request of %0d cycles with no ack issued", nx_len));
          else begin
            int w; w = next_len_q.pop_front();
            chk(nx_len == w, "next_len", $sformatf("got %0d cycles, want %0d", nx_len, w));
          end
          nx_len = 0;
        end
        sw_prev = sw_swap;
        if (sw_start && real_start)        base_cyc = cyc + 1;
        if (sw_next_itr && sw_next_itr_ack) base_cyc = cyc + 1;
      end
    end
  end

  initial begin : swap_ack_drv
    bit act; int d;
    act = 0; d = 0; sw_swap_ack = 0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin act = 0; sw_swap_ack = 0; end
      else if (sw_swap) begin
        if (!act) begin act = 1; d = pick_delay(); swap_len_q.push_back(d + 1); end
        sw_swap_ack = (d == 0);
        if (d > 0) d--;
      end else begin
        act = 0;
        sw_swap_ack = (ack_mode == 0) || (spurious && $urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin : next_ack_drv
    bit act; int d;
    act = 0; d = 0; sw_next_itr_ack = 0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin act = 0; sw_next_itr_ack = 0; end
      else if (sw_next_itr) begin
        if (!act) begin act = 1; d = pick_delay(); next_len_q.push_back(d + 1); end
        sw_next_itr_ack = (d == 0);
        if (d > 0) d--;
      end else begin
        act = 0;
        sw_next_itr_ack = (ack_mode == 0) || (spurious && $urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk(fr_s_val == '0,    {tag, "_fr_s_val"}, $sformatf("got %h, want 0", fr_s_val));
    chk(sw_swap == 1'b0,   {tag, "_sw_swap"},  $sformatf("got %b, want 0", sw_swap));
    chk(sw_next_itr == 1'b0, {tag, "_sw_next_itr"}, $sformatf("got %b, want 0", sw_next_itr));
    chk(sw_pe_en == 1'b0,  {tag, "_sw_pe_en"}, $sformatf("got %b, want 0", sw_pe_en));
    chk(pe_taps == '0,     {tag, "_pe_taps"},  $sformatf("got %h, want 0", pe_taps));
    chk(line_itr == '0,    {tag, "_line_itr"}, $sformatf("got %0d, want 0", line_itr));
    chk(busy == 1'b0,      {tag, "_busy"},     $sformatf("got %b, want 0", busy));
    chk(done == 1'b0,      {tag, "_done"},     $sformatf("got %b, want 0", done));
  endtask

  task automatic fill_mem(input bit ident);
    for (int i = 0; i < 1024; i++) mem[i] = ident ? DW'(i) : DW'($urandom);
  endtask

  task automatic kick(input bit dir, input int init, input int base, input int shb);
    @(posedge clk); #2;
    sw_dir = dir; sw_mp_accu_init = AW'(init); sw_mp_accu_base = AW'(base); sw_sh_accu_base = AW'(shb);
    sw_start = 1; real_start = 1;
    @(posedge clk); #2;
    sw_start = 0; real_start = 0;
    sw_dir = ~dir; sw_mp_accu_init = AW'($urandom); sw_mp_accu_base = AW'($urandom); sw_sh_accu_base = AW'($urandom);
  endtask

  task automatic run(input bit dir, input int init, input int base, input int shb, input bit spur);
    int t;
    expect_run(dir, init, base, shb);
    kick(dir, init, base, shb);
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(posedge clk); #2; t++;
      sw_start = spur && (exp_q.size() >= 2) && ($urandom_range(0, 4) == 0);
    end
    sw_start = 0;
    chk(exp_q.size() == 0, "run_complete", $sformatf("%0d events outstanding after %0d cycles, want 0", exp_q.size(), t));
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic reset_mid();
    bit seen;
    expect_run(0, 'h300, 'h100, 'h200);
    kick(0, 'h300, 'h100, 'h200);
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin @(posedge clk); #2; seen = sw_pe_en; end
    chk(seen, "pe_en_before_reset", $sformatf("got pe_en=%b, want 1", seen));
    @(posedge clk); #3;
    reset = 1; #1;
    check_zero("mid_rst");
    exp_q.delete(); swap_len_q.delete(); next_len_q.delete();
    @(posedge clk); #2;
    reset = 0;
    run(0, 'h300, 'h100, 'h200, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1; sw_start = 0; sw_dir = 0;
    sw_mp_accu_init = '0; sw_mp_accu_base = '0; sw_sh_accu_base = '0;
    fill_mem(1);
    repeat (2) @(posedge clk);
    #2;
    check_zero("rst");
    @(posedge clk); #2;
    reset = 0;

    ack_mode = 2; run(0, 'h300, 'h100, 'h200, 0);      // basic ascending
    run(1, 'h300, 'h100, 'h200, 0);                   // descending
    run(0, -'h200, 'h80, 'h40, 0);                    // clamp at 0
    run(0, 'h3FA00, 'h100, 'h80, 0);                  // clamp at 1023
    ack_mode = 0; run(0, 'h300, 'h100, 'h200, 0);      // ack held high
    ack_mode = 1; run(1, 'h300, 'h100, 'h200, 0);      // ack delayed 5
    ack_mode = 2; spurious = 1; run(0, 'h300, 'h100, 'h200, 0);
    spurious = 0;
    reset_mid();
    run(0, 'h300, 'h100, 'h200, 1);                   // start while busy

    fill_mem(0);
    for (int r = 0; r < 4; r++) begin
      int init, base, shb;
      init = int'(wrap(longint'($urandom_range(0, (1 << AW) - 1))));
      base = int'($urandom_range(0, 'h800)) - 'h400;
      shb  = int'($urandom_range(0, 'h2000)) - 'h1000;
      spurious = (r % 2 == 1);
      run(1'($urandom_range(0, 1)), init, base, shb, r >= 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
